prio_encoder_seq: RTL

//  Parametrised, sequential successor to the 4-to-2 encoder. Latches an N-bit request vector,

---
 rtl/prio_encoder_seq.sv | 88 ++++++++
 1 files changed

// File: rtl/prio_encoder_seq.sv
// prio_encoder_seq: latches a request vector and emits the index of each set bit over a valid/ready port
module prio_encoder_seq #(
  parameter int N       = 8,
  parameter int IDX_W   = $clog2(N),
  parameter int RR_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [N-1:0]     req_i,
  output logic             load_ready_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic             done_o,
  output logic             busy_o
);
  typedef enum logic {IDLE, SCAN} state_e;
  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d, one_hot;
  logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, sel, start;
  logic             valid_q, valid_d, done_q, done_d, slot;
  int               p;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ptr_q     <= IDX_W'(N - 1);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
    end
  end
  // Downward search from start with wrap; the last hit written is the nearest to start.
  always_comb begin
    start   = (RR_MODE != 0) ? ptr_q : IDX_W'(N - 1);
    sel     = '0;
    p       = 0;
    one_hot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = int'(start) - k;
      p = (p < 0) ? p + N : p;
      if (pending_q[IDX_W'(p)]) sel = IDX_W'(p);
    end
    one_hot[sel] = 1'b1;
  end
  assign slot = ~valid_q | idx_ready_i;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (en_i && |req_i) ? SCAN : IDLE;
    else if (slot && ~|pending_q) state_d = IDLE;
  end
  always_comb begin
    pending_d = pending_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    ptr_d     = ptr_q;
    if (state_q == IDLE) begin
      pending_d = en_i ? req_i : pending_q;
      done_d    = en_i & ~|req_i;
    end else if (slot) begin
      if (|pending_q) begin
        idx_d     = sel;
        valid_d   = 1'b1;
        pending_d = pending_q & ~one_hot;
        ptr_d     = (RR_MODE == 0) ? ptr_q : (sel == '0) ? IDX_W'(N - 1) : sel - 1'b1;
      end else begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end
  end
  always_comb begin
    load_ready_o = state_q == IDLE;
    busy_o       = state_q == SCAN;
    idx_o        = idx_q;
    idx_valid_o  = valid_q;
    done_o       = done_q;
  end
endmodule
